// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone B4 cycle/burst type codes, wb_ram FSM states and burst address helper.
`default_nettype none

package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } wb_state_e;

  // Linear bursts use an all-ones mask; wrap bursts stay inside the aligned block.
  function automatic logic [31:0] burst_next(input logic [31:0] adr,
                                             input logic [1:0]  bte,
                                             input int          nb);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'(nb);
    case (bte)
      BTE_WRAP4:  mask = 32'(4 * nb - 1);
      BTE_WRAP8:  mask = 32'(8 * nb - 1);
      BTE_WRAP16: mask = 32'(16 * nb - 1);
      default:    mask = '1;
    endcase
    return (adr & ~mask) | ((adr + step) & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ram_array.sv
// wb_ram_array: byte-lane-writable synchronous single-port array with registered read data.
`default_nettype none

module wb_ram_array #(
  parameter int DEPTH      = 4096,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 12
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on purpose: keeps the array mappable onto block/SPRAM primitives.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
          if (sel[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_ram.sv
// wb_ram: Wishbone B4 classic slave RAM with wait states and range/alignment error.
// Optional registered-feedback bursts when WB_RAM_BURST_EN is defined.
`default_nettype none

module wb_ram
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int          SIZE         = 16384,
  parameter int          DATA_WIDTH   = 32,
  parameter int          WAIT_STATES  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [31:0]             adr_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o
);

  localparam int          NB         = DATA_WIDTH / 8;
  localparam int          LSB        = $clog2(NB);
  localparam int          DEPTH      = SIZE / NB;
  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);

  wb_state_e             state, state_n;
  logic [3:0]            cnt;
  logic [31:0]           adr_q;
  logic                  we_q;
  logic [NB-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  rd_valid;

  logic                  beat;
  logic                  in_range;
  logic [31:0]           offset;
  logic [AW-1:0]         word_idx;
  logic                  mem_en;
  logic [NB-1:0]         mem_sel;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // 33-bit compare so BASE_ADDRESS + SIZE never wraps.
  assign in_range = ({1'b0, adr_q} >= {1'b0, BASE_ADDRESS})
                 && ({1'b0, adr_q} < ({1'b0, BASE_ADDRESS} + 33'(SIZE)))
                 && ((adr_q & ALIGN_MASK) == 32'd0);
  assign offset   = adr_q - BASE_ADDRESS;
  assign word_idx = AW'(offset >> LSB);

  always_comb begin
    state_n = state;
    beat    = 1'b0;
    case (state)
      IDLE: begin
        // ack/err still high means a termination just happened: enforce one idle cycle.
        if (cyc_i && stb_i && !ack_o && !err_o)
          state_n = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (!cyc_i)
          state_n = IDLE;
        else if (cnt == 4'(WAIT_STATES - 1))
          state_n = RESP;
      end
      RESP: begin
        beat    = 1'b1;
        state_n = IDLE;
`ifdef WB_RAM_BURST_EN
        if (cti_i == CTI_INCR && in_range) state_n = BURST;
`endif
      end
      BURST: begin
`ifdef WB_RAM_BURST_EN
        if (!cyc_i) begin
          state_n = IDLE;
        end else if (stb_i) begin
          beat = 1'b1;
          if (cti_i == CTI_END || !in_range) state_n = IDLE;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_en    = beat && in_range;
  assign mem_sel   = (state == BURST) ? sel_i : sel_q;
  assign mem_wdata = (state == BURST) ? dat_i : dat_q;

`ifndef WB_RAM_BURST_EN
  logic unused_burst;
  assign unused_burst = ^{cti_i, bte_i};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      adr_q    <= 32'd0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_n;
      ack_o <= beat && in_range;
      err_o <= beat && !in_range;
      cnt   <= (state == WAIT) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && state_n != IDLE) begin
        adr_q <= adr_i;
        we_q  <= we_i;
        sel_q <= sel_i;
        dat_q <= dat_i;
      end
`ifdef WB_RAM_BURST_EN
      if (beat && in_range) adr_q <= burst_next(adr_q, bte_i, NB);
`endif
      if (beat && in_range && !we_q) rd_valid <= 1'b1;
    end
  end

  // The array read register holds the last read word; rd_valid gives dat_o its reset value.
  assign dat_o = rd_valid ? mem_rdata : '0;
  assign rty_o = 1'b0;

  wb_ram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_array (
    .clk   (clk_i),
    .en    (mem_en),
    .we    (we_q),
    .sel   (mem_sel),
    .addr  (word_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_ram.sv
// tb_wb_ram: directed self-checking bench for wb_ram (one zero-wait and one three-wait instance).
`default_nettype none

module tb_wb_ram;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SZ   = 1024;

  logic        clk;
  logic        rst;
  logic [1:0]  cyc;
  logic [1:0]  stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1, rty0, rty1;

  int checks = 0;
  int errors = 0;

  wb_ram #(.BASE_ADDRESS(BASE), .SIZE(SZ), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .cti_i(cti), .bte_i(bte),
    .dat_o(dat0), .ack_o(ack0), .err_o(err0), .rty_o(rty0)
  );

  wb_ram #(.BASE_ADDRESS(BASE), .SIZE(SZ), .DATA_WIDTH(32), .WAIT_STATES(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .cti_i(cti), .bte_i(bte),
    .dat_o(dat1), .ack_o(ack1), .err_o(err1), .rty_o(rty1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One classic access on instance k; lat = edges from request capture to termination.
  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic got_ack, output logic got_err);
    @(negedge clk);
    we = w; adr = a; sel = s; dat = d; cti = 3'b000; bte = 2'b00;
    cyc[k] = 1'b1; stb[k] = 1'b1;
    lat = -1; rd = '0; got_ack = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if ((k == 0) ? (ack0 | err0) : (ack1 | err1)) begin
        lat     = i;
        got_ack = (k == 0) ? ack0 : ack1;
        got_err = (k == 0) ? err0 : err1;
        rd      = (k == 0) ? dat0 : dat1;
        break;
      end
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk); #1;
    check("term_one_cycle", {62'd0, (k == 0) ? {ack0, err0} : {ack1, err1}}, 64'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        ga, ge;
  int          stray;

  initial begin
    rst = 1'b1; cyc = '0; stb = '0; we = 1'b0; adr = '0; sel = '0; dat = '0;
    cti = 3'b000; bte = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack0", {63'd0, ack0}, 64'd0);
    check("rst_err0", {63'd0, err0}, 64'd0);
    check("rst_rty0", {63'd0, rty0}, 64'd0);
    check("rst_dat0", {32'd0, dat0}, 64'd0);
    check("rst_dat1", {32'd0, dat1}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Zero wait states: full-word write then read.
    access(0, 1'b1, BASE + 32'h4, 4'hF, 32'hDEADBEEF, lat, rd, ga, ge);
    check("wr_ack", {63'd0, ga}, 64'd1);
    check("wr_lat", 64'(lat), 64'd1);
    access(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0, lat, rd, ga, ge);
    check("rd_lat", 64'(lat), 64'd1);
    check("rd_data", {32'd0, rd}, {32'd0, 32'hDEADBEEF});

    // Byte-lane merge.
    access(0, 1'b1, BASE + 32'h10, 4'hF, 32'h11223344, lat, rd, ga, ge);
    access(0, 1'b1, BASE + 32'h10, 4'b0101, 32'hAABBCCDD, lat, rd, ga, ge);
    check("lane_wr_ack", {63'd0, ga}, 64'd1);
    access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, lat, rd, ga, ge);
    check("lane_merge", {32'd0, rd}, {32'd0, 32'h11BB33DD});

    // sel all zero: acked, memory unchanged.
    access(0, 1'b1, BASE + 32'h4, 4'h0, 32'hFFFFFFFF, lat, rd, ga, ge);
    check("sel0_ack", {63'd0, ga}, 64'd1);
    access(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0, lat, rd, ga, ge);
    check("sel0_keep", {32'd0, rd}, {32'd0, 32'hDEADBEEF});

    // Last valid word.
    access(0, 1'b1, BASE + SZ - 4, 4'hF, 32'h5A5A0FF0, lat, rd, ga, ge);
    access(0, 1'b0, BASE + SZ - 4, 4'hF, 32'h0, lat, rd, ga, ge);
    check("top_word", {32'd0, rd}, {32'd0, 32'h5A5A0FF0});

    // Error terminations: above, below, misaligned.
    access(0, 1'b1, BASE, 4'hF, 32'h01020304, lat, rd, ga, ge);
    access(0, 1'b1, BASE + SZ, 4'hF, 32'hEEEEEEEE, lat, rd, ga, ge);
    check("err_hi", {62'd0, ga, ge}, 64'd1);
    check("err_hi_lat", 64'(lat), 64'd1);
    access(0, 1'b1, BASE - 4, 4'hF, 32'hEEEEEEEE, lat, rd, ga, ge);
    check("err_lo", {62'd0, ga, ge}, 64'd1);
    access(0, 1'b1, BASE + 2, 4'hF, 32'hEEEEEEEE, lat, rd, ga, ge);
    check("err_mis", {62'd0, ga, ge}, 64'd1);
    check("err_dat_hold", {32'd0, dat0}, {32'd0, 32'h5A5A0FF0});
    access(0, 1'b0, BASE + SZ, 4'hF, 32'h0, lat, rd, ga, ge);
    check("err_rd", {62'd0, ga, ge}, 64'd1);
    access(0, 1'b0, BASE, 4'hF, 32'h0, lat, rd, ga, ge);
    check("err_no_wr", {32'd0, rd}, {32'd0, 32'h01020304});
    access(0, 1'b0, BASE + SZ - 4, 4'hF, 32'h0, lat, rd, ga, ge);
    check("err_no_wr_top", {32'd0, rd}, {32'd0, 32'h5A5A0FF0});

    // Three wait states.
    access(1, 1'b1, BASE + 32'h20, 4'hF, 32'hCAFEF00D, lat, rd, ga, ge);
    check("ws3_wr_lat", 64'(lat), 64'd4);
    access(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, lat, rd, ga, ge);
    check("ws3_rd_lat", 64'(lat), 64'd4);
    check("ws3_rd_data", {32'd0, rd}, {32'd0, 32'hCAFEF00D});

    // Master abandons a waited write after two cycles.
    @(negedge clk);
    we = 1'b1; adr = BASE + 32'h20; sel = 4'hF; dat = 32'h12345678;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1; cyc[1] = 1'b0; stb[1] = 1'b0;
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack1 || err1) stray++;
    end
    check("abort_no_term", 64'(stray), 64'd0);
    access(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, lat, rd, ga, ge);
    check("abort_no_wr", {32'd0, rd}, {32'd0, 32'hCAFEF00D});

    // Asynchronous reset while a write is in WAIT.
    @(negedge clk);
    we = 1'b1; adr = BASE + 32'h20; sel = 4'hF; dat = 32'h0BADF00D;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("arst_ack", {63'd0, ack1}, 64'd0);
    check("arst_err", {63'd0, err1}, 64'd0);
    check("arst_dat", {32'd0, dat1}, 64'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk); rst = 1'b0;
    access(1, 1'b0, BASE + 32'h20, 4'hF, 32'h0, lat, rd, ga, ge);
    check("arst_next_lat", 64'(lat), 64'd4);
    check("arst_no_wr", {32'd0, rd}, {32'd0, 32'hCAFEF00D});
    access(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0, lat, rd, ga, ge);
    check("arst_ram_kept", {32'd0, rd}, {32'd0, 32'h11BB33DD});

`ifdef WB_RAM_BURST_EN
    begin
      logic [31:0] got [4];
      int          at  [4];
      int          nb;
      access(0, 1'b1, BASE + 32'h0, 4'hF, 32'hA0A0A0A0, lat, rd, ga, ge);
      access(0, 1'b1, BASE + 32'h4, 4'hF, 32'hA1A1A1A1, lat, rd, ga, ge);
      access(0, 1'b1, BASE + 32'h8, 4'hF, 32'hA2A2A2A2, lat, rd, ga, ge);
      access(0, 1'b1, BASE + 32'hC, 4'hF, 32'hA3A3A3A3, lat, rd, ga, ge);
      @(negedge clk);
      we = 1'b0; adr = BASE + 32'h8; sel = 4'hF; cti = 3'b010; bte = 2'b01;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      nb = 0;
      for (int i = 0; i < 20 && nb < 4; i++) begin
        @(posedge clk); #1;
        if (ack0) begin
          got[nb] = dat0; at[nb] = i; nb++;
          if (nb == 3) cti = 3'b111;
        end
      end
      cyc[0] = 1'b0; stb[0] = 1'b0; cti = 3'b000; bte = 2'b00;
      check("bst_beats", 64'(nb), 64'd4);
      if (nb == 4) begin
        check("bst_d0", {32'd0, got[0]}, {32'd0, 32'hA2A2A2A2});
        check("bst_d1", {32'd0, got[1]}, {32'd0, 32'hA3A3A3A3});
        check("bst_d2", {32'd0, got[2]}, {32'd0, 32'hA0A0A0A0});
        check("bst_d3", {32'd0, got[3]}, {32'd0, 32'hA1A1A1A1});
        check("bst_first", 64'(at[0]), 64'd1);
        check("bst_back2back", 64'(at[3] - at[0]), 64'd3);
      end
      @(posedge clk); #1;
      check("bst_idle", {62'd0, ack0, err0}, 64'd0);
      access(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0, lat, rd, ga, ge);
      check("bst_after_lat", 64'(lat), 64'd1);
      check("bst_after_data", {32'd0, rd}, {32'd0, 32'hA1A1A1A1});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
